// File: rtl/tdm_frame_receiver.sv
// TDM frame receiver: aligns a slot-serial sample stream on frame-start
// markers, gathers one complete frame in a shadow buffer and publishes it
// in parallel. Partial or misframed data never reaches the output.
module tdm_frame_receiver #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                s_data,
  input  logic                                 s_valid,
  input  logic                                 s_frame_start,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   channelOutputData,
  output logic                                 frame_valid,
  output logic                                 frame_err,
  output logic                                 locked,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] slot_idx
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                               state_r, state_nx_s;
  logic [IDX_W-1:0]                     slot_idx_r, idx_nx_s;
  logic [DATA_WIDTH-1:0]                shadow_r [NUM_CHANNELS];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_out_r;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   frame_s;
  logic                                 frame_valid_r;
  logic                                 frame_err_r;
  logic                                 locked_r;
  logic                                 wr_en_s;
  logic [IDX_W-1:0]                     wr_idx_s;
  logic                                 done_s;
  logic                                 err_s;

  // The completed frame is the shadow contents with the final slot taken
  // straight from the input, so it can be published on the same edge.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_frame
    if (g == NUM_CHANNELS - 1) begin : g_last
      assign frame_s[g*DATA_WIDTH +: DATA_WIDTH] = s_data;
    end else begin : g_shadow
      assign frame_s[g*DATA_WIDTH +: DATA_WIDTH] = shadow_r[g];
    end
  end

  // Next-state, slot pointer and per-sample actions for the HUNT/LOCKED FSM.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = slot_idx_r;
    wr_en_s    = 1'b0;
    wr_idx_s   = slot_idx_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    if (s_valid) begin
      case (state_r)
        HUNT: begin
          if (s_frame_start) begin
            wr_en_s    = 1'b1;
            wr_idx_s   = IDX_ZERO;
            state_nx_s = LOCKED;
            if (NUM_CHANNELS == 1) begin
              done_s   = 1'b1;
              idx_nx_s = IDX_ZERO;
            end else begin
              idx_nx_s = IDX_ONE;
            end
          end else begin
            state_nx_s = HUNT;
          end
        end
        LOCKED: begin
          if (slot_idx_r == IDX_ZERO) begin
            if (s_frame_start) begin
              // Normal start of the next frame.
              wr_en_s    = 1'b1;
              wr_idx_s   = IDX_ZERO;
              state_nx_s = LOCKED;
              if (NUM_CHANNELS == 1) begin
                done_s   = 1'b1;
                idx_nx_s = IDX_ZERO;
              end else begin
                idx_nx_s = IDX_ONE;
              end
            end else begin
              // Missing sync: drop the sample and lose lock.
              err_s      = 1'b1;
              state_nx_s = HUNT;
              idx_nx_s   = IDX_ZERO;
            end
          end else begin
            if (s_frame_start) begin
              // Early sync: abandon the partial frame and restart at slot 0.
              err_s      = 1'b1;
              wr_en_s    = 1'b1;
              wr_idx_s   = IDX_ZERO;
              state_nx_s = LOCKED;
              idx_nx_s   = IDX_ONE;
            end else begin
              wr_en_s  = 1'b1;
              wr_idx_s = slot_idx_r;
              if (slot_idx_r == IDX_LAST) begin
                done_s   = 1'b1;
                idx_nx_s = IDX_ZERO;
              end else begin
                idx_nx_s = slot_idx_r + IDX_ONE;
              end
            end
          end
        end
        default: begin
          state_nx_s = HUNT;
          idx_nx_s   = IDX_ZERO;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // State, slot pointer and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= HUNT;
      slot_idx_r    <= IDX_ZERO;
      locked_r      <= 1'b0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      slot_idx_r    <= idx_nx_s;
      locked_r      <= (state_nx_s == LOCKED);
      frame_valid_r <= done_s;
      frame_err_r   <= err_s;
    end
  end

  // Shadow buffer collecting the slots of the frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_en_s && (wr_idx_s == IDX_W'(i))) begin
          shadow_r[i] <= s_data;
        end else begin
          shadow_r[i] <= shadow_r[i];
        end
      end
    end
  end

  // Published frame register, updated only when a frame completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_r <= {(NUM_CHANNELS*DATA_WIDTH){1'b0}};
    end else if (done_s) begin
      data_out_r <= frame_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign channelOutputData = data_out_r;
  assign frame_valid       = frame_valid_r;
  assign frame_err         = frame_err_r;
  assign locked            = locked_r;
  assign slot_idx          = slot_idx_r;

endmodule

// File: tb/tb_tdm_frame_receiver.sv
// Directed self-checking bench for tdm_frame_receiver (4 slots x 16 bits).
module tb_tdm_frame_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_frame_start = 1'b0;
  logic [63:0] channelOutputData;
  logic        frame_valid;
  logic        frame_err;
  logic        locked;
  logic [1:0]  slot_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t1 = 0;
  int t2 = 0;

  tdm_frame_receiver #(.NUM_CHANNELS(4), .DATA_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_frame_start     (s_frame_start),
    .channelOutputData (channelOutputData),
    .frame_valid       (frame_valid),
    .frame_err         (frame_err),
    .locked            (locked),
    .slot_idx          (slot_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // frame_valid and frame_err must be mutually exclusive on every cycle.
  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      assert (!(frame_valid && frame_err)) else begin
        n_err++;
        $error("FAIL excl obs=%0b%0b exp=not both", frame_valid, frame_err);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Present one accepted sample; returns 1 time unit after the capturing edge.
  task automatic send(input logic fs, input logic [15:0] d);
    s_valid = 1'b1;
    s_frame_start = fs;
    s_data = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_data", channelOutputData, 64'h0);
    chk("rst_fv", frame_valid, 64'h0);
    chk("rst_fe", frame_err, 64'h0);
    chk("rst_lock", locked, 64'h0);
    chk("rst_idx", slot_idx, 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Nominal frame
    send(1'b1, 16'h1111);
    chk("nom_lock", locked, 64'h1);
    chk("nom_idx1", slot_idx, 64'h1);
    send(1'b0, 16'h2222);
    send(1'b0, 16'h3333);
    chk("nom_fv_early", frame_valid, 64'h0);
    chk("nom_data_early", channelOutputData, 64'h0);
    send(1'b0, 16'h4444);
    chk("nom_fv", frame_valid, 64'h1);
    chk("nom_fe", frame_err, 64'h0);
    chk("nom_data", channelOutputData, 64'h4444_3333_2222_1111);
    chk("nom_idx_wrap", slot_idx, 64'h0);
    idle(1);
    chk("nom_fv_pulse", frame_valid, 64'h0);

    // Missing sync
    send(1'b0, 16'h0009);
    chk("miss_fe", frame_err, 64'h1);
    chk("miss_lock", locked, 64'h0);
    chk("miss_idx", slot_idx, 64'h0);
    chk("miss_data", channelOutputData, 64'h4444_3333_2222_1111);
    idle(1);
    chk("miss_fe_pulse", frame_err, 64'h0);

    // Hunt: unsynced samples ignored
    send(1'b0, 16'hAAAA);
    chk("hunt_fe", frame_err, 64'h0);
    chk("hunt_lock", locked, 64'h0);
    send(1'b0, 16'hBBBB);
    chk("hunt_idx", slot_idx, 64'h0);
    send(1'b1, 16'h0101);
    chk("hunt_lock_up", locked, 64'h1);
    send(1'b0, 16'h0202);
    send(1'b0, 16'h0303);
    send(1'b0, 16'h0404);
    chk("hunt_fv", frame_valid, 64'h1);
    chk("hunt_data", channelOutputData, 64'h0404_0303_0202_0101);

    // Early sync
    send(1'b1, 16'h0001);
    send(1'b0, 16'h0002);
    send(1'b1, 16'h0005);
    chk("early_fe", frame_err, 64'h1);
    chk("early_lock", locked, 64'h1);
    chk("early_idx", slot_idx, 64'h1);
    chk("early_data_hold", channelOutputData, 64'h0404_0303_0202_0101);
    send(1'b0, 16'h0006);
    chk("early_fe_pulse", frame_err, 64'h0);
    send(1'b0, 16'h0007);
    send(1'b0, 16'h0008);
    chk("early_fv", frame_valid, 64'h1);
    chk("early_data", channelOutputData, 64'h0008_0007_0006_0005);

    // Gaps between slots
    send(1'b1, 16'h1111);
    idle(3);
    send(1'b0, 16'h2222);
    idle(3);
    chk("gap_idx", slot_idx, 64'h2);
    chk("gap_fv", frame_valid, 64'h0);
    send(1'b0, 16'h3333);
    idle(3);
    send(1'b0, 16'h4444);
    chk("gap_fv_done", frame_valid, 64'h1);
    chk("gap_data", channelOutputData, 64'h4444_3333_2222_1111);

    // Reset mid-frame
    send(1'b1, 16'h5555);
    send(1'b0, 16'h6666);
    reset = 1'b0;
    #2;
    chk("mrst_data", channelOutputData, 64'h0);
    chk("mrst_lock", locked, 64'h0);
    chk("mrst_idx", slot_idx, 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    send(1'b1, 16'h00A1);
    chk("mrst_first_lock", locked, 64'h1);
    send(1'b0, 16'h00B2);
    send(1'b0, 16'h00C3);
    send(1'b0, 16'h00D4);
    chk("mrst_fv", frame_valid, 64'h1);
    chk("mrst_data2", channelOutputData, 64'h00D4_00C3_00B2_00A1);

    // Back-to-back frames
    idle(2);
    send(1'b1, 16'h0011);
    send(1'b0, 16'h0022);
    send(1'b0, 16'h0033);
    send(1'b0, 16'h0044);
    chk("b2b_fv1", frame_valid, 64'h1);
    t1 = cyc;
    send(1'b1, 16'h0055);
    chk("b2b_fv1_end", frame_valid, 64'h0);
    chk("b2b_fe", frame_err, 64'h0);
    send(1'b0, 16'h0066);
    send(1'b0, 16'h0077);
    send(1'b0, 16'h0088);
    chk("b2b_fv2", frame_valid, 64'h1);
    t2 = cyc;
    chk("b2b_spacing", 64'(t2 - t1), 64'h4);
    chk("b2b_data", channelOutputData, 64'h0088_0077_0066_0055);
    chk("b2b_fe2", frame_err, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_frame_receiver.md
TDM_FRAME_RECEIVER -- requirements
Module: tdm_frame_receiver

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4, number of TDM slots per frame (legal range 1..64).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, width of one sample.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port s_data  input  DATA_WIDTH  serial TDM sample for the current slot.
REQ-006 The block SHALL have port s_valid  input  1  s_data qualifier; the sample is accepted on a rising clk edge with s_valid=1.
REQ-007 The block SHALL have port s_frame_start  input  1  marks the accepted sample as slot 0; ignored when s_valid=0.
REQ-008 The block SHALL have port channelOutputData  output  NUM_CHANNELS*DATA_WIDTH  last complete frame, slot i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port frame_valid  output  1  one-cycle pulse when channelOutputData updates.
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse on a framing violation.
REQ-011 The block SHALL have port locked  output  1  high while in state LOCKED.
REQ-012 The block SHALL have port slot_idx  output  max(1,clog2(NUM_CHANNELS))  slot index expected for the next accepted sample.

Function
REQ-013 The FSM SHALL have exactly two states: HUNT and LOCKED.
REQ-014 In HUNT, accepted samples with s_frame_start=0 SHALL be discarded with no output change and no frame_err.
REQ-015 In HUNT, an accepted sample with s_frame_start=1 SHALL be stored as slot 0, the FSM SHALL go to LOCKED, and slot_idx SHALL become 1 (0 if NUM_CHANNELS=1).
REQ-016 In LOCKED, an accepted sample with s_frame_start=0 at slot_idx!=0 SHALL be stored in shadow[slot_idx], and slot_idx SHALL increment.
REQ-017 When the accepted sample is slot NUM_CHANNELS-1, slot_idx SHALL wrap to 0, all NUM_CHANNELS samples (shadow plus this sample) SHALL be copied to channelOutputData on that same edge, and frame_valid SHALL be 1 for the following cycle only; the latency from the last-slot acceptance edge to visible output is 1 edge.
REQ-018 In LOCKED, an accepted sample with s_frame_start=1 at slot_idx!=0 (early sync) SHALL pulse frame_err, discard the partial frame, store the sample as slot 0, set slot_idx to 1, and remain LOCKED.
REQ-019 In LOCKED, an accepted sample with s_frame_start=0 at slot_idx=0 (missing sync) SHALL pulse frame_err, discard the sample, go to HUNT, and set slot_idx to 0.
REQ-020 In LOCKED, an accepted sample with s_frame_start=1 at slot_idx=0 SHALL be the normal start of the next frame with no error.
REQ-021 When NUM_CHANNELS=1, every accepted sample with s_frame_start=1 SHALL complete a frame (frame_valid pulse), and s_frame_start=0 in LOCKED SHALL follow REQ-019.
REQ-022 Cycles with s_valid=0 SHALL hold all state, with gaps of any length allowed mid-frame.
REQ-023 channelOutputData SHALL change only on frame completion; discarded or partial frames SHALL never be visible.
REQ-024 frame_valid and frame_err SHALL never both be 1 in the same cycle.
REQ-025 Samples SHALL be stored unmodified, with no arithmetic and no width change.

Reset
REQ-026 While reset=0, the state SHALL be HUNT, slot_idx=0, shadow=0, channelOutputData=0, frame_valid=0, frame_err=0, and locked=0, asynchronously.
REQ-027 Reset deassertion mid-frame SHALL restart in HUNT with the prior partial frame lost, and the first acceptance SHALL take effect at the first rising clk edge after reset=1.

Verification
REQ-028 Nominal case (N=4, W=16): sync+0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles -> frame_valid pulses one cycle after 0x4444, channelOutputData = {0x4444,0x3333,0x2222,0x1111}, frame_err=0.
REQ-029 Hunt case: 0xAAAA and 0xBBBB without sync, then a full frame -> first two samples ignored, locked rises after the sync sample, one frame_valid, output matches the frame only.
REQ-030 Early sync case: sync+0x1, 0x2, sync+0x5, 0x6, 0x7, 0x8 -> frame_err pulses at the third sample, locked stays 1, output becomes {0x8,0x7,0x6,0x5}.
REQ-031 Missing sync case: a full frame, then 0x9 without sync -> frame_err pulse, locked=0, slot_idx=0, output unchanged.
REQ-032 Gaps and reset case: a frame with s_valid=0 gaps of 3 cycles between slots gives the same result as REQ-028; reset=0 asserted after slot 2 -> outputs 0 immediately, and the next frame is captured cleanly.
REQ-033 Back-to-back case: two frames with no idle cycles -> two frame_valid pulses exactly 4 cycles apart, no frame_err.
